// File: rtl/display_scan_mux3_pkg.sv
// Shared types and constants for the 3-digit 7-segment scan multiplexer.
package display_scan_mux3_pkg;

  typedef logic [6:0] seg7_t;

  // Scan order: units first, then tens, then hundreds.
  typedef enum logic [1:0] {
    DIG_U = 2'd0,
    DIG_T = 2'd1,
    DIG_H = 2'd2
  } digit_e;

  localparam seg7_t SEG_ZERO = 7'b0111111;
  localparam seg7_t SEG_OFF  = 7'h00;

  // Next digit in the scan sequence; the unused encoding recovers to units.
  function automatic digit_e next_digit(input digit_e d);
    case (d)
      DIG_U:   return DIG_T;
      DIG_T:   return DIG_H;
      default: return DIG_U;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_mux3_if.sv
// Segment-pattern inputs and display-drive outputs of the scan multiplexer.
interface display_scan_mux3_if;
  import display_scan_mux3_pkg::*;

  seg7_t      seg_centenas_in;
  seg7_t      seg_decenas_in;
  seg7_t      seg_unidades_in;
  logic       blank_lz;
  seg7_t      seg_out;
  logic [2:0] an_out;
  logic       frame_start;

  // Upstream decoder side: supplies patterns, observes the display drive.
  modport master (
    output seg_centenas_in, seg_decenas_in, seg_unidades_in, blank_lz,
    input  seg_out, an_out, frame_start
  );

  // Multiplexer side.
  modport slave (
    input  seg_centenas_in, seg_decenas_in, seg_unidades_in, blank_lz,
    output seg_out, an_out, frame_start
  );
endinterface

// File: rtl/display_scan_mux3_refresh_prescaler.sv
// Free-running slot counter 0..DIV-1 with a wrap indication on the last count.
module refresh_prescaler #(
  parameter int DIV = 50000,
  localparam int CW = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Count up and return to zero after the last count of the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign wrap = (cnt_reg == LAST);

endmodule

// File: rtl/display_scan_mux3.sv
// Time-multiplexed driver for a 3-digit common-anode 7-segment display with
// ghosting blanks, frame-coherent snapshots and leading-zero blanking.
module display_scan_mux3
  import display_scan_mux3_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  display_scan_mux3_if.slave   bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam seg7_t      SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  logic [CW-1:0] div_cnt;
  logic          div_wrap;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .cnt   (div_cnt),
    .wrap  (div_wrap)
  );

  digit_e     digit_reg;
  seg7_t      cent_s_reg, dec_s_reg, unid_s_reg;
  logic       blank_lz_s_reg;
  seg7_t      cent_s_next, dec_s_next, unid_s_next;
  logic       blank_lz_s_next;
  logic       snap_now;
  logic       lz_h, lz_t;
  logic       in_blank;
  logic [2:0] digit_en;
  logic [2:0] an_lit;
  seg7_t      seg_pick, seg_lit;
  seg7_t      seg_out_reg;
  logic [2:0] an_out_reg;
  logic       frame_start_reg;

  assign snap_now = (div_cnt == '0) && (digit_reg == DIG_U);

  // Advance to the next digit each time the slot counter wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_reg <= DIG_U;
    end else if (div_wrap) begin
      digit_reg <= next_digit(digit_reg);
    end
  end

  // Capture all three patterns together at the start of each frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cent_s_reg     <= SEG_OFF;
      dec_s_reg      <= SEG_OFF;
      unid_s_reg     <= SEG_OFF;
      blank_lz_s_reg <= 1'b0;
    end else if (snap_now) begin
      cent_s_reg     <= bus.seg_centenas_in;
      dec_s_reg      <= bus.seg_decenas_in;
      unid_s_reg     <= bus.seg_unidades_in;
      blank_lz_s_reg <= bus.blank_lz;
    end
  end

  // The output register reads the snapshot being loaded on the same edge, so
  // the first cycle of a frame never shows the previous frame's pattern.
  always_comb begin
    cent_s_next     = snap_now ? bus.seg_centenas_in : cent_s_reg;
    dec_s_next      = snap_now ? bus.seg_decenas_in  : dec_s_reg;
    unid_s_next     = snap_now ? bus.seg_unidades_in : unid_s_reg;
    blank_lz_s_next = snap_now ? bus.blank_lz        : blank_lz_s_reg;
  end

  assign lz_h     = blank_lz_s_next && (cent_s_next == SEG_ZERO);
  assign lz_t     = lz_h && (dec_s_next == SEG_ZERO);
  assign digit_en = {~lz_h, ~lz_t, 1'b1};

  if (BLANK_CYCLES == 0) begin : g_no_gap
    assign in_blank = 1'b0;
  end else begin : g_gap
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    assign in_blank = (div_cnt < BLANK_LIM);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_an
    assign an_lit[gi] = !in_blank && (int'(digit_reg) == gi) && digit_en[gi];
  end

  // Select the current digit's pattern; dark whenever no anode is enabled.
  always_comb begin
    seg_pick = SEG_OFF;
    case (digit_reg)
      DIG_U:   seg_pick = unid_s_next;
      DIG_T:   seg_pick = dec_s_next;
      DIG_H:   seg_pick = cent_s_next;
      default: seg_pick = SEG_OFF;
    endcase
    seg_lit = (|an_lit) ? seg_pick : SEG_OFF;
  end

  // Register the drive outputs, applying the board polarity only here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_out_reg     <= SEG_IDLE;
      an_out_reg      <= AN_IDLE;
      frame_start_reg <= 1'b0;
    end else begin
      seg_out_reg     <= (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
      an_out_reg      <= (AN_ACTIVE_LOW != 0) ? ~an_lit : an_lit;
      frame_start_reg <= snap_now;
    end
  end

  assign bus.seg_out     = seg_out_reg;
  assign bus.an_out      = an_out_reg;
  assign bus.frame_start = frame_start_reg;

endmodule
